// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
package pipeline_ctrl_pkg;

    typedef enum logic {
        RUN     = 1'b0,
        MD_WAIT = 1'b1
    } state_e;

    localparam logic [4:0]  REG_ZERO       = 5'd0;
    localparam int unsigned MD_TIMEOUT_DEF = 40;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard check between the D instruction and a load in X.
module load_use_detect
    import pipeline_ctrl_pkg::*;
(
    input  logic [4:0] fd_rs_i,
    input  logic [4:0] fd_rt_i,
    input  logic       fd_uses_rs_i,
    input  logic       fd_uses_rt_i,
    input  logic [4:0] dx_rd_i,
    input  logic       dx_is_load_i,
    output logic       hazard_o
);

    logic rs_hit;
    logic rt_hit;

    always_comb begin
        rs_hit   = fd_uses_rs_i && (fd_rs_i == dx_rd_i);
        rt_hit   = fd_uses_rt_i && (fd_rt_i == dx_rd_i);
        // r0 is hardwired, so a load targeting it never creates a dependency
        hazard_o = dx_is_load_i && (dx_rd_i != REG_ZERO) && (rs_hit || rt_hit);
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard/stall controller: latch enables and flushes for PC, F/D, D/X, X/M,
// plus mult/div start/ready sequencing with timeout and a stall counter.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned MD_TIMEOUT = MD_TIMEOUT_DEF,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [4:0]       fd_rs,
    input  logic [4:0]       fd_rt,
    input  logic             fd_uses_rs,
    input  logic             fd_uses_rt,
    input  logic [4:0]       dx_rd,
    input  logic             dx_is_load,
    input  logic             dx_is_md,
    input  logic             md_ready,
    input  logic             br_taken,
    output logic             pc_wren,
    output logic             fd_wren,
    output logic             dx_wren,
    output logic             xm_wren,
    output logic             fd_flush,
    output logic             dx_flush,
    output logic             xm_flush,
    output logic             md_start,
    output logic             md_busy,
    output logic             md_timeout,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int unsigned       WCNT_W    = (MD_TIMEOUT > 2) ? $clog2(MD_TIMEOUT) : 1;
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(MD_TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic              tmo_q, tmo_d;
    logic [CNT_W-1:0]  stall_q, stall_d;

    logic hazard;
    logic pc_we, fd_we, dx_we, xm_we;
    logic fd_fl, dx_fl, xm_fl;
    logic start, busy;

    load_use_detect u_lud (
        .fd_rs_i      (fd_rs),
        .fd_rt_i      (fd_rt),
        .fd_uses_rs_i (fd_uses_rs),
        .fd_uses_rt_i (fd_uses_rt),
        .dx_rd_i      (dx_rd),
        .dx_is_load_i (dx_is_load),
        .hazard_o     (hazard)
    );

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        tmo_d   = tmo_q;
        pc_we   = 1'b1;
        fd_we   = 1'b1;
        dx_we   = 1'b1;
        xm_we   = 1'b1;
        fd_fl   = 1'b0;
        dx_fl   = 1'b0;
        xm_fl   = 1'b0;
        start   = 1'b0;
        busy    = 1'b0;
        case (state_q)
            RUN: begin
                if (dx_is_md) begin
                    start   = 1'b1;
                    pc_we   = 1'b0;
                    fd_we   = 1'b0;
                    dx_we   = 1'b0;
                    xm_fl   = 1'b1;
                    wcnt_d  = '0;
                    state_d = MD_WAIT;
                end else if (br_taken) begin
                    fd_fl = 1'b1;
                    dx_fl = 1'b1;
                end else if (hazard) begin
                    pc_we = 1'b0;
                    fd_we = 1'b0;
                    dx_fl = 1'b1;
                end
            end
            MD_WAIT: begin
                busy = 1'b1;
                if (md_ready || (wcnt_q == WCNT_LAST)) begin
                    state_d = RUN;
                    if (!md_ready) begin
                        tmo_d = 1'b1;
                    end
                end else begin
                    pc_we  = 1'b0;
                    fd_we  = 1'b0;
                    dx_we  = 1'b0;
                    xm_fl  = 1'b1;
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        stall_d = stall_q;
        if (!pc_we && (stall_q != '1)) begin
            stall_d = stall_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= RUN;
            wcnt_q  <= '0;
            tmo_q   <= 1'b0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            tmo_q   <= tmo_d;
            stall_q <= stall_d;
        end
    end

    // Mealy controls are forced low while reset is held so no latch moves.
    assign pc_wren    = reset & pc_we;
    assign fd_wren    = reset & fd_we;
    assign dx_wren    = reset & dx_we;
    assign xm_wren    = reset & xm_we;
    assign fd_flush   = reset & fd_fl;
    assign dx_flush   = reset & dx_fl;
    assign xm_flush   = reset & xm_fl;
    assign md_start   = reset & start;
    assign md_busy    = reset & busy;
    assign md_timeout = tmo_q;
    assign stall_cnt  = stall_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: vector table, directed multi-cycle
// sequences and randomized traffic against a cycle-level reference model.
module tb_pipeline_ctrl;

    localparam int unsigned TO  = 8;
    localparam int unsigned CW  = 6;
    localparam int          SAT = (1 << CW) - 1;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic [4:0]    fd_rs = '0, fd_rt = '0, dx_rd = '0;
    logic          fd_uses_rs = 1'b0, fd_uses_rt = 1'b0;
    logic          dx_is_load = 1'b0, dx_is_md = 1'b0, md_ready = 1'b0, br_taken = 1'b0;
    logic          pc_wren, fd_wren, dx_wren, xm_wren;
    logic          fd_flush, dx_flush, xm_flush;
    logic          md_start, md_busy, md_timeout;
    logic [CW-1:0] stall_cnt;

    always #5 clock = ~clock;

    pipeline_ctrl #(.MD_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clock      (clock),
        .reset      (reset),
        .fd_rs      (fd_rs),
        .fd_rt      (fd_rt),
        .fd_uses_rs (fd_uses_rs),
        .fd_uses_rt (fd_uses_rt),
        .dx_rd      (dx_rd),
        .dx_is_load (dx_is_load),
        .dx_is_md   (dx_is_md),
        .md_ready   (md_ready),
        .br_taken   (br_taken),
        .pc_wren    (pc_wren),
        .fd_wren    (fd_wren),
        .dx_wren    (dx_wren),
        .xm_wren    (xm_wren),
        .fd_flush   (fd_flush),
        .dx_flush   (dx_flush),
        .xm_flush   (xm_flush),
        .md_start   (md_start),
        .md_busy    (md_busy),
        .md_timeout (md_timeout),
        .stall_cnt  (stall_cnt)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: whether a mul/div is outstanding, how many wait cycles
    // it has used, the sticky timeout and the stall tally.
    bit m_wait;
    int m_waited;
    bit m_tmo;
    int m_stall;

    // Tallies of observed DUT behaviour for the directed sequences.
    int c_start, c_busy, c_pc0, c_xmf;

    typedef struct {
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
        logic       urs;
        logic       urt;
        logic       ld;
        logic       br;
        logic [6:0] ctl;   // {pc,fd,dx,xm wren, fd,dx,xm flush}
    } vec_t;

    vec_t tbl[10];

    function automatic logic [15:0] dut_vec();
        return {pc_wren, fd_wren, dx_wren, xm_wren, fd_flush, dx_flush, xm_flush,
                md_start, md_busy, md_timeout, stall_cnt};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic set_in(input int rs, input int rt, input bit urs, input bit urt,
                          input int rd, input bit ld, input bit md, input bit rdy, input bit br);
        fd_rs      = 5'(rs);
        fd_rt      = 5'(rt);
        fd_uses_rs = urs;
        fd_uses_rt = urt;
        dx_rd      = 5'(rd);
        dx_is_load = ld;
        dx_is_md   = md;
        md_ready   = rdy;
        br_taken   = br;
    endtask

    task automatic idle();
        set_in(1, 2, 1'b1, 1'b1, 5, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // One clock cycle: predict, compare mid-cycle, then advance the model.
    // Entered and left at posedge+1 with inputs already applied.
    task automatic cycle(input string tag);
        logic [6:0]  ctl;
        logic [15:0] exp;
        bit          start, rel, hz;
        hz = dx_is_load && (dx_rd != 0) &&
             ((fd_uses_rs && fd_rs == dx_rd) || (fd_uses_rt && fd_rt == dx_rd));
        start = 1'b0;
        rel   = 1'b0;
        if (m_wait) begin
            rel = md_ready || (m_waited + 1 >= TO);
            ctl = rel ? 7'b1111_000 : 7'b0001_001;
        end else if (dx_is_md) begin
            ctl   = 7'b0001_001;
            start = 1'b1;
        end else if (br_taken) begin
            ctl = 7'b1111_110;
        end else if (hz) begin
            ctl = 7'b0011_010;
        end else begin
            ctl = 7'b1111_000;
        end
        exp = {ctl, start, m_wait, m_tmo, CW'(m_stall)};
        @(negedge clock);
        check(tag, 32'(dut_vec()), 32'(exp));
        c_start += int'(md_start);
        c_busy  += int'(md_busy);
        c_pc0   += int'(!pc_wren);
        c_xmf   += int'(xm_flush);
        @(posedge clock);
        if (!ctl[6]) m_stall = (m_stall < SAT) ? m_stall + 1 : SAT;
        if (m_wait) begin
            if (rel) begin
                m_wait = 1'b0;
                if (!md_ready) m_tmo = 1'b1;
            end else begin
                m_waited++;
            end
        end else if (dx_is_md) begin
            m_wait   = 1'b1;
            m_waited = 0;
        end
        #1;
    endtask

    task automatic clr_tally();
        c_start = 0; c_busy = 0; c_pc0 = 0; c_xmf = 0;
    endtask

    // Asynchronous reset pulse asserted mid-cycle; outputs must drop at once.
    task automatic do_reset(input string tag);
        #2;
        reset = 1'b0;
        #1;
        check({tag, "_zero"}, 32'(dut_vec()), 32'd0);
        m_wait = 1'b0; m_waited = 0; m_tmo = 1'b0; m_stall = 0;
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        int s0;
        m_wait = 1'b0; m_waited = 0; m_tmo = 1'b0; m_stall = 0;
        clr_tally();

        tbl[0] = '{5'd1,  5'd2,  5'd3,  1'b1, 1'b1, 1'b1, 1'b0, 7'b1111_000};
        tbl[1] = '{5'd3,  5'd2,  5'd3,  1'b1, 1'b1, 1'b1, 1'b0, 7'b0011_010};
        tbl[2] = '{5'd1,  5'd3,  5'd3,  1'b1, 1'b1, 1'b1, 1'b0, 7'b0011_010};
        tbl[3] = '{5'd3,  5'd4,  5'd3,  1'b0, 1'b1, 1'b1, 1'b0, 7'b1111_000};
        tbl[4] = '{5'd0,  5'd0,  5'd0,  1'b1, 1'b1, 1'b1, 1'b0, 7'b1111_000};
        tbl[5] = '{5'd3,  5'd3,  5'd3,  1'b1, 1'b1, 1'b0, 1'b0, 7'b1111_000};
        tbl[6] = '{5'd3,  5'd2,  5'd3,  1'b1, 1'b1, 1'b1, 1'b1, 7'b1111_110};
        tbl[7] = '{5'd1,  5'd2,  5'd3,  1'b1, 1'b1, 1'b0, 1'b1, 7'b1111_110};
        tbl[8] = '{5'd0,  5'd31, 5'd31, 1'b1, 1'b1, 1'b1, 1'b0, 7'b0011_010};
        tbl[9] = '{5'd7,  5'd7,  5'd7,  1'b0, 1'b1, 1'b1, 1'b0, 7'b0011_010};

        // Reset state
        idle();
        #3;
        check("reset_low_outputs", 32'(dut_vec()), 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        cycle("after_reset");

        // Decode-side vectors in RUN
        foreach (tbl[i]) begin
            set_in(int'(tbl[i].rs), int'(tbl[i].rt), tbl[i].urs, tbl[i].urt,
                   int'(tbl[i].rd), tbl[i].ld, 1'b0, 1'b0, tbl[i].br);
            #2;
            check($sformatf("tbl%0d_ctl", i),
                  32'({pc_wren, fd_wren, dx_wren, xm_wren, fd_flush, dx_flush, xm_flush}),
                  32'(tbl[i].ctl));
            cycle($sformatf("tbl%0d", i));
        end

        // Load-use costs exactly one stall, then normal flow
        s0 = int'(stall_cnt);
        set_in(3, 4, 1'b1, 1'b1, 3, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle("lu_stall");
        idle();
        cycle("lu_resume");
        check("lu_stall_cnt", 32'(stall_cnt), 32'(s0 + 1));

        // Branch together with hazard: squash, no stall
        s0 = int'(stall_cnt);
        set_in(3, 4, 1'b1, 1'b1, 3, 1'b1, 1'b0, 1'b0, 1'b1);
        cycle("br_hz");
        idle();
        cycle("br_after");
        check("br_stall_cnt", 32'(stall_cnt), 32'(s0));

        // Mult/div: ready in the start cycle is ignored, real ready 4 cycles later
        s0 = int'(stall_cnt);
        clr_tally();
        set_in(1, 2, 1'b1, 1'b1, 5, 1'b0, 1'b1, 1'b1, 1'b0);
        cycle("md_start");
        md_ready = 1'b0;
        for (int k = 1; k < 4; k++) cycle("md_wait");
        md_ready = 1'b1;
        cycle("md_release");
        idle();
        cycle("md_after");
        check("md_start_pulses", 32'(c_start), 32'd1);
        check("md_busy_cycles", 32'(c_busy), 32'd4);
        check("md_pc_stall_cycles", 32'(c_pc0), 32'd4);
        check("md_xm_flush_cycles", 32'(c_xmf), 32'd4);
        check("md_stall_cnt", 32'(stall_cnt), 32'(s0 + 4));
        check("md_no_timeout", 32'(md_timeout), 32'd0);

        // Back-to-back mult/div
        clr_tally();
        set_in(1, 2, 1'b1, 1'b1, 5, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle("b2b_start1");
        cycle("b2b_wait1");
        md_ready = 1'b1;
        cycle("b2b_rel1");
        md_ready = 1'b0;
        #2;
        check("b2b_start2_now", 32'(md_start), 32'd1);
        cycle("b2b_start2");
        md_ready = 1'b1;
        cycle("b2b_rel2");
        idle();
        cycle("b2b_after");
        check("b2b_start_pulses", 32'(c_start), 32'd2);

        // Timeout with md_ready held low
        clr_tally();
        set_in(1, 2, 1'b1, 1'b1, 5, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle("to_start");
        for (int k = 0; k < int'(TO) - 1; k++) cycle("to_wait");
        dx_is_md = 1'b0;
        cycle("to_release");
        idle();
        cycle("to_after");
        check("to_busy_cycles", 32'(c_busy), 32'(TO));
        check("to_flag_set", 32'(md_timeout), 32'd1);
        for (int k = 0; k < 5; k++) cycle("to_hold");
        check("to_flag_sticky", 32'(md_timeout), 32'd1);

        // Reset in the middle of MD_WAIT
        set_in(1, 2, 1'b1, 1'b1, 5, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle("rst_md_start");
        cycle("rst_md_wait");
        do_reset("rst_mid_wait");
        idle();
        cycle("rst_run");
        check("rst_stall_cnt", 32'(stall_cnt), 32'd0);

        // Stall counter saturation
        set_in(9, 9, 1'b1, 1'b0, 9, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < SAT + 6; k++) cycle("sat_run");
        check("sat_value", 32'(stall_cnt), 32'(SAT));
        do_reset("sat_clear");

        // Randomized traffic
        for (int n = 0; n < 800; n++) begin
            if (n % 200 == 199) do_reset("rnd_reset");
            set_in(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                   1'($urandom % 2), 1'($urandom % 2), int'($urandom_range(0, 3)),
                   ($urandom % 3) == 0, ($urandom % 8) == 0,
                   ($urandom % 6) == 0, ($urandom % 5) == 0);
            cycle("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
